// File: rtl/s2p_pkg.sv
// s2p_pkg: shared helpers for the s2p_multi deserializer.
// Holds the counter-width function, the lane-slice helper and the
// shift-register reset constant. Optional flush is built with S2P_FLUSH_EN.
package s2p_pkg;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of lane 'lane' inside the packed multi-lane output word
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Value every shift-register bit takes on reset or clear
    localparam logic SHIFT_RST_BIT = 1'b0;

endpackage

// File: rtl/s2p_lane.sv
// s2p_lane: one serial lane. It holds a WIDTH-bit shift/insert register.
// The position counter is shared and is owned by the top level.
// o_word is the word as it would stand after this cycle's sample. The top
// level captures that value when a word completes or is flushed.
module s2p_lane
    import s2p_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic             i_bit,
    input  logic [CNT_W-1:0] i_bit_cnt,
    output logic [WIDTH-1:0] o_word
);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_next;

    // Insert the incoming bit: shift in at bit 0, or write at the count position
    always_comb begin
        w_next = r_shift;
        if (MSB_FIRST != 0) begin
            w_next = {r_shift[WIDTH-2:0], i_bit};
        end else begin
            w_next[i_bit_cnt] = i_bit;
        end
    end

    assign o_word = i_tick ? w_next : r_shift;

    // Shift register: cleared on word emit / disable, loaded on each sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= {WIDTH{SHIFT_RST_BIT}};
        end else if (i_clear) begin
            r_shift <= {WIDTH{SHIFT_RST_BIT}};
        end else if (i_tick) begin
            r_shift <= w_next;
        end
    end

endmodule

// File: rtl/s2p_multi.sv
// s2p_multi: multi-lane serial-to-parallel deserializer.
// Handshake: out_data is offered while out_valid is high. A word is
// transferred on a rising clk edge where out_valid and out_ready are both high.
// out_data and out_valid do not change while out_valid is high and
// out_ready is low, except that enable low discards the pending word.
// Building with S2P_FLUSH_EN adds the flush input and the out_bits output.
module s2p_multi
    import s2p_pkg::*;
#(
    parameter int CHANNELS  = 16,
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      tick,
    input  logic [CHANNELS-1:0]       in,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic                      busy
`ifdef S2P_FLUSH_EN
    ,
    input  logic                      flush,
    output logic [$clog2(WIDTH+1)-1:0] out_bits
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]          r_bit_cnt;
    logic [CHANNELS*WIDTH-1:0] r_out_data;
    logic                      r_out_valid;
    logic                      r_overflow;

    logic                      w_tick;
    logic                      w_last;
    logic                      w_flush_emit;
    logic                      w_emit;
    logic                      w_can_load;
    logic                      w_lane_clear;
    logic [CHANNELS*WIDTH-1:0] w_words;

    assign w_tick       = enable & tick;
    assign w_last       = w_tick & (r_bit_cnt == LAST_CNT);
`ifdef S2P_FLUSH_EN
    // A flush emits only when at least one bit is held, counting this cycle's sample
    assign w_flush_emit = enable & flush & ~w_last & (w_tick | (r_bit_cnt != '0));
`else
    assign w_flush_emit = 1'b0;
`endif
    assign w_emit       = w_last | w_flush_emit;
    assign w_can_load   = ~r_out_valid | out_ready;
    assign w_lane_clear = ~enable | w_emit;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        s2p_lane #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_clear   (w_lane_clear),
            .i_tick    (w_tick),
            .i_bit     (in[c]),
            .i_bit_cnt (r_bit_cnt),
            .o_word    (w_words[lane_lsb(c, WIDTH) +: WIDTH])
        );
    end

    // Bit counter, output register, valid flag and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (!enable) begin
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_emit) begin
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_emit && w_can_load) begin
                r_out_data  <= w_words;
                r_out_valid <= 1'b1;
            end else if (w_emit) begin
                // Consumer is stalling on the held word: drop the new one
                r_overflow  <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef S2P_FLUSH_EN
    localparam int BITS_W = $clog2(WIDTH + 1);
    logic [BITS_W-1:0] r_out_bits;
    logic [BITS_W-1:0] w_emit_bits;

    assign w_emit_bits = w_last ? BITS_W'(WIDTH)
                                : BITS_W'(r_bit_cnt) + BITS_W'(w_tick);

    // Valid-bit count travels with the word into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bits <= '0;
        end else if (enable && w_emit && w_can_load) begin
            r_out_bits <= w_emit_bits;
        end
    end

    assign out_bits = r_out_bits;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign busy      = (r_bit_cnt != '0);

endmodule

// File: tb/tb_s2p_multi.sv
// tb_s2p_multi: drives an MSB-first and an LSB-first s2p_multi (CHANNELS=2,
// WIDTH=4) with shared stimulus. Both are checked against a bit-list model.
// Set S2P_FLUSH_EN for the flush steps.
module tb_s2p_multi;

    localparam int CH = 2;
    localparam int W  = 4;
    localparam int DW = CH * W;

    logic          clk;
    logic          clk_run;
    logic          rst_n;
    logic          enable;
    logic          tick;
    logic [CH-1:0] in_bits;
    logic          out_ready;
    logic          flush;
    logic [DW-1:0] od [2];
    logic          ov [2];
    logic          of [2];
    logic          bz [2];
    logic [2:0]    ob [2];

    int checks = 0;
    int errors = 0;

    // Model state: received bits per lane in arrival order
    bit            rx [CH][W];
    int            m_cnt;
    bit            m_valid [2];
    logic [DW-1:0] m_data [2];
    bit            m_ovf [2];
    int            m_bits [2];
    logic [DW-1:0] exp_q [$];

    // Clock block
    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    s2p_multi #(.CHANNELS(CH), .WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .in(in_bits),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .overflow(of[0]), .busy(bz[0])
`ifdef S2P_FLUSH_EN
        , .flush(flush), .out_bits(ob[0])
`endif
    );

    s2p_multi #(.CHANNELS(CH), .WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .in(in_bits),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .overflow(of[1]), .busy(bz[1])
`ifdef S2P_FLUSH_EN
        , .flush(flush), .out_bits(ob[1])
`endif
    );

`ifndef S2P_FLUSH_EN
    assign ob[0] = '0;
    assign ob[1] = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k received bits: MSB-first puts the first at k-1, LSB-first at 0
    function automatic logic [DW-1:0] build(input bit msb, input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < k; i++)
            for (int c = 0; c < CH; c++)
                w[c*W + (msb ? (k - 1 - i) : i)] = rx[c][i];
        return w;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            m_data[d]  = '0;
            m_ovf[d]   = 0;
            m_bits[d]  = 0;
        end
        exp_q.delete();
    endtask

    // Advance the model by one clock using the current (pre-edge) inputs
    task automatic model_step();
        logic [DW-1:0] e;
        bit emit;
        int k;
        if (enable && m_valid[0] && out_ready) begin
            e = 'x;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("sb_xfer", 32'(od[0]), 32'(e));
        end
        if (!enable) begin
            m_cnt = 0;
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0;
                m_ovf[d]   = 0;
            end
            exp_q.delete();
        end else begin
            if (tick) begin
                for (int c = 0; c < CH; c++) rx[c][m_cnt] = in_bits[c];
                m_cnt++;
            end
            k = m_cnt;
            emit = (k == W);
`ifdef S2P_FLUSH_EN
            if (!emit && flush && k != 0) emit = 1;
`endif
            for (int d = 0; d < 2; d++) begin
                if (emit) begin
                    if (!m_valid[d] || out_ready) begin
                        m_data[d]  = build(d == 0, k);
                        m_valid[d] = 1;
                        m_bits[d]  = k;
                        if (d == 0) exp_q.push_back(m_data[d]);
                    end else begin
                        m_ovf[d] = 1;
                    end
                end else if (m_valid[d] && out_ready) begin
                    m_valid[d] = 0;
                end
            end
            if (emit) m_cnt = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid%0d", d), 32'(ov[d]), 32'(m_valid[d]));
            if (m_valid[d]) chk($sformatf("data%0d", d), 32'(od[d]), 32'(m_data[d]));
            chk($sformatf("ovf%0d", d), 32'(of[d]), 32'(m_ovf[d]));
            chk($sformatf("busy%0d", d), 32'(bz[d]), 32'(m_cnt != 0));
`ifdef S2P_FLUSH_EN
            if (m_valid[d]) chk($sformatf("bits%0d", d), 32'(ob[d]), 32'(m_bits[d]));
`endif
        end
    endtask

    // Driver: one clock with the inputs currently applied
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic tick_bits(input logic [CH-1:0] b);
        tick = 1'b1;
        in_bits = b;
        cycle();
        tick = 1'b0;
    endtask

    initial begin
        logic [3:0] ch0;
        logic [3:0] ch1;
        clk_run = 1'b1;
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; in_bits = '0;
        out_ready = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_data", 32'(od[d]), 32'h0);
            chk("rst_valid", 32'(ov[d]), 32'h0);
            chk("rst_ovf", 32'(of[d]), 32'h0);
            chk("rst_busy", 32'(bz[d]), 32'h0);
        end
        rst_n = 1'b1;
        enable = 1'b1;

        // Known word: ch0 1,0,1,1 / ch1 0,0,1,0
        ch0 = 4'b1011; ch1 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick_bits({ch1[3-i], ch0[3-i]});
            chk("t1_busy", 32'(bz[0]), (i < 3) ? 32'h1 : 32'h0);
        end
        chk("t1_valid", 32'(ov[0]), 32'h1);
        chk("t1_data_msb", 32'(od[0]), 32'h2B);
        chk("t1_data_lsb", 32'(od[1]), 32'h4D);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Eight back-to-back ticks; the 8th lands on the transfer of word 1
        for (int i = 0; i < 8; i++) begin
            out_ready = (i == 7);
            tick_bits(CH'($urandom_range(0, 3)));
            if (i >= 3) chk("t2_valid", 32'(ov[0]), 32'h1);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t2_ovf", 32'(of[0]), 32'h0);

        // Stalled consumer: the second word is dropped and overflow sticks
        for (int i = 0; i < 8; i++) tick_bits(CH'($urandom_range(0, 3)));
        chk("t3_ovf", 32'(of[0]), 32'h1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t3_valid_after", 32'(ov[0]), 32'h0);
        chk("t3_ovf_sticky", 32'(of[0]), 32'h1);

        // Enable low mid-word discards the partial word
        tick_bits(2'b11);
        tick_bits(2'b11);
        enable = 1'b0;
        tick_bits(2'b11);
        chk("t4_busy", 32'(bz[0]), 32'h0);
        chk("t4_ovf", 32'(of[0]), 32'h0);
        enable = 1'b1;
        tick_bits(2'b01);
        tick_bits(2'b00);
        tick_bits(2'b10);
        tick_bits(2'b00);
        chk("t4_lsb_lane0", 32'(od[1][3:0]), 32'h1);
        chk("t4_msb_lane0", 32'(od[0][3:0]), 32'h8);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Asynchronous reset mid-word with the clock held low
        tick_bits(2'b10);
        tick_bits(2'b11);
        @(negedge clk);
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_data", 32'(od[d]), 32'h0);
            chk("arst_valid", 32'(ov[d]), 32'h0);
            chk("arst_ovf", 32'(of[d]), 32'h0);
            chk("arst_busy", 32'(bz[d]), 32'h0);
        end
        model_reset();
        #2 rst_n = 1'b1;
        clk_run = 1'b1;
        for (int i = 0; i < 4; i++) tick_bits(CH'($urandom_range(0, 3)));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

`ifdef S2P_FLUSH_EN
        // Partial word via flush, then flush when idle
        tick_bits(2'b11);
        tick_bits(2'b11);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_lane0_msb", 32'(od[0][3:0]), 32'h3);
        chk("fl_lane0_lsb", 32'(od[1][3:0]), 32'h3);
        chk("fl_bits", 32'(ob[0]), 32'h2);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_idle_valid", 32'(ov[0]), 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            enable    = ($urandom_range(0, 29) != 0);
            tick      = ($urandom_range(0, 9) < 7);
            in_bits   = CH'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef S2P_FLUSH_EN
            flush     = ($urandom_range(0, 9) == 0);
`endif
            cycle();
        end
        tick = 1'b0; flush = 1'b0; out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
